keystream_xor_stream: RTL
=========================

Name: keystream_xor_stream

Overview:
- Parametrised stream-cipher datapath. It accepts plaintext words over a valid/ready handshake and XORs each word with one keystream word from the keystream generator.
- Results are buffered in an internal FIFO and presented on a valid/ready output toward the UART transmit side.
- It replaces the fixed-width byte glue logic with configurable data width and FIFO depth, plus a bypass mode, explicit enable/drain/flush control and backpressure.

Parameters:
- DATA_W, 8, word width in bits; multiple of 8, 8..64.
- DEPTH, 4, FIFO entries; power of 2, 2..64.
- CNT_W, 16, width of the processed-word counter (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- enable  in  1  1 = accept input; 0 = stop accepting and drain.
- flush  in  1  synchronous pulse; discards FIFO contents.
- bypass  in  1  1 = pass data through unmodified, no keystream consumed.
- in_data  in  DATA_W  plaintext word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept in_data this cycle.
- ks_data  in  DATA_W  keystream word.
- ks_valid  in  1  ks_data valid.
- ks_read  out  1  combinational pulse; consumes ks_data this cycle.
- out_data  out  DATA_W  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  sink takes out_data this cycle.
- busy  out  1  state != IDLE.
- count  out  CNT_W  words written to FIFO (optional feature only).

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, FIFO empty, in_ready=0, out_valid=0, out_data=0, ks_read=0, busy=0, count=0.
- States:
  - IDLE: in_ready=0. Goes to RUN when enable=1 and flush=0.
  - RUN: in_ready = !full && (bypass || ks_valid). Goes to DRAIN when enable=0.
  - DRAIN: in_ready=0; output side keeps popping. Goes to IDLE when FIFO is empty. Returns to RUN if enable=1 again before empty.
- Accept = in_valid && in_ready.
  - On accept with bypass=0: ks_read=1 in the same cycle; FIFO writes in_data ^ ks_data.
  - On accept with bypass=1: ks_read=0; FIFO writes in_data.
- ks_read is never asserted without an accept, so no keystream word is lost or reused.
- Latency: a word accepted at edge N appears on out_data with out_valid=1 after edge N (first-word fall-through). Minimum one cycle, input to output.
- Pop = out_valid && out_ready; head advances at the next edge.
- Full FIFO: in_ready=0 even if a pop occurs in the same cycle; no push-through when full.
- Empty FIFO: a simultaneous push and pop is legal only when not empty. When empty, a push makes out_valid=1 next cycle.
- Pointers are log2(DEPTH)+1 bits wrapping modulo 2*DEPTH. Full/empty are derived from the MSB compare.
- flush=1 (highest priority after rst):
  - pointers cleared, out_valid=0 next cycle, state=IDLE;
  - no accept and ks_read=0 in the flush cycle;
  - count unaffected.
- bypass is sampled per accept; mixing modes across words is legal.
- Toggling enable mid-word has no effect on words already accepted.
- Reset mid-operation discards all buffered words.

Optional Feature:
- Macro XOR_STREAM_STATS_EN.
- Defined: count port exists. count increments by 1 on every FIFO write and wraps at 2^CNT_W. It is cleared only by rst.
- Undefined: count port and counter are absent; CNT_W is ignored.

Decomposition:
- Package cipher_stream_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2);
  - function clog2_depth;
  - constant MIN_DEPTH=2.
- One sub-module, stream_sync_fifo (parametrised WIDTH, DEPTH), with push/pop/full/empty/clear and first-word-fall-through read.
- The FSM and XOR stay in the top.

Test Plan:
- Basic encrypt: DATA_W=8, enable=1, bypass=0, ks_data=8'hA5 with ks_valid=1, in_data=8'h3C -> out_data=8'h99 one cycle after accept, ks_read pulses exactly once.
- Keystream stall: ks_valid=0 with in_valid=1 -> in_ready=0, ks_read=0, no FIFO write. Raising ks_valid -> accept the same cycle.
- Full/backpressure: DEPTH=4, out_ready=0, push 6 words -> 4 accepted, in_ready=0 afterwards. Release out_ready -> words drain in order, and in_ready returns the cycle after the first pop.
- Bypass and DATA_W=32: bypass=1, in_data=32'hDEADBEEF -> out_data=32'hDEADBEEF, ks_read never asserted.
- Drain and flush: 3 words buffered, enable=0 -> busy stays 1 until the 3 pops, then IDLE. Repeat with flush after 2 words -> out_valid=0 next cycle, busy=0.
- Async reset mid-stream: rst asserted between edges with the FIFO half full -> all outputs 0 immediately; count=0 with XOR_STREAM_STATS_EN.

Source files
------------

// File: rtl/cipher_stream_pkg.sv
// Shared types and helpers for the keystream XOR stream datapath.
// Holds the controller state encoding, the minimum FIFO depth and a log2 helper for pointer sizing.
package cipher_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int MIN_DEPTH = 2;

    // Number of address bits needed to index 'depth' entries.
    function automatic int clog2_depth(input int depth);
        int n;
        n = 0;
        while ((1 << n) < depth) n++;
        return n;
    endfunction

endpackage

// File: rtl/keystream_xor_stream_if.sv
// Handshake bundle for keystream_xor_stream: plaintext input, keystream input and ciphertext output.
// 'master' is the surrounding system; 'slave' is the datapath block.
interface keystream_xor_stream_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] ks_data;
    logic              ks_valid;
    logic              ks_read;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, ks_data, ks_valid, out_ready,
        input  in_ready, ks_read, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, ks_data, ks_valid, out_ready,
        output in_ready, ks_read, out_data, out_valid
    );
endinterface

// File: rtl/stream_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a synchronous clear.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB compare.
module stream_sync_fifo
    import cipher_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = clog2_depth(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en    = push && !full;
    assign rd_en    = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; empty gates pop_data, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/keystream_xor_stream.sv
// Stream cipher datapath: XORs accepted plaintext with one keystream word and buffers the result.
// Optional processed-word counter on port 'count' is built when XOR_STREAM_STATS_EN is defined.
module keystream_xor_stream
    import cipher_stream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   flush,
    input  logic                   bypass,
    keystream_xor_stream_if.slave  bus,
    output logic                   busy
`ifdef XOR_STREAM_STATS_EN
    ,
    output logic [CNT_W-1:0]       count
`endif
);
    if (DATA_W < 8 || DATA_W > 64 || (DATA_W % 8) != 0 ||
        DEPTH < MIN_DEPTH || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 ||
        CNT_W < 1) begin : g_param_check
        $error("keystream_xor_stream: unsupported parameter combination");
    end

    state_e            state;
    logic              fifo_full;
    logic              fifo_empty;
    logic              can_accept;
    logic              accept;
    logic              pop;
    logic [DATA_W-1:0] fifo_wdata;

    // Flush blocks acceptance so its cycle never consumes a keystream word.
    assign can_accept = (state == RUN) && !flush && !fifo_full && (bypass || bus.ks_valid);
    assign accept     = bus.in_valid && can_accept;
    assign pop        = !fifo_empty && bus.out_ready;
    assign fifo_wdata = bypass ? bus.in_data : (bus.in_data ^ bus.ks_data);

    assign bus.in_ready  = can_accept;
    assign bus.ks_read   = accept && !bypass;
    assign bus.out_valid = !fifo_empty;

    stream_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (accept),
        .push_data (fifo_wdata),
        .pop       (pop),
        .pop_data  (bus.out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (enable) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
                RUN: if (!enable) state <= DRAIN;
                DRAIN: begin
                    if (enable) begin
                        state <= RUN;
                    end else if (fifo_empty) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef XOR_STREAM_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Counts FIFO writes only; flush leaves it alone, reset alone clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         count <= '0;
        else if (accept) count <= count + CNT_ONE;
    end
`endif

endmodule
